seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..16).
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each digit is driven (legal >= 1).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port i_value  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) is digit k, digit 0 rightmost.
REQ-006 Port i_dp  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-007 Port i_en  input  NUM_DIGITS  digit enable mask, 0 = digit fully blank.
REQ-008 Port i_lzs  input  1  leading-zero suppression mode, 1 = on.
REQ-009 Port i_load  input  1  one-cycle strobe capturing i_value and i_dp.
REQ-010 Port o_an  output  NUM_DIGITS  digit select, active-low, one-cold.
REQ-011 Port o_seg  output  8  segments, active-low; bit7..bit1 = a..g, bit0 = dp.
REQ-012 Port o_frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count the digit index advances by 1.
REQ-014 Digit index wraps NUM_DIGITS-1 -> 0; that advance is the frame boundary.
REQ-015 o_frame is 1 in exactly the cycle after the frame-boundary edge, else 0.
REQ-016 i_load=1 captures i_value/i_dp into a pending register and sets pending-valid.
REQ-017 At a frame boundary with pending-valid=1, pending copies to the display shadow and pending-valid clears.
REQ-018 i_load coinciding with a frame boundary: the newly presented i_value/i_dp go directly to shadow, pending-valid stays 0.
REQ-019 i_load repeated before a boundary: last value wins.
REQ-020 Segment patterns (active-high, before inversion, a..g,dp): 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 E6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E; o_seg is the bitwise inverse.
REQ-021 dp: when shadow dp for the current digit is 1, o_seg[0] = 0, independent of nibble value.
REQ-022 LZS: with i_lzs=1, digit k (k >= 1) is suppressed when it and every higher digit are 0 in shadow; digit 0 never suppressed.
REQ-023 Suppressed digit: o_seg segments a..g all 1; dp still follows REQ-021; o_an still selects it.
REQ-024 i_en[k]=0: while digit k is scanned, o_an all 1 and o_seg = FF (overrides LZS and dp).
REQ-025 i_en and i_lzs are sampled live, not via shadow.
REQ-026 o_an and o_seg are registered; they reflect the digit index of the previous cycle (1-cycle latency from index change).
REQ-027 o_an has at most one bit 0 in any cycle.
REQ-028 NUM_DIGITS=1: index constant 0, o_frame pulses every SCAN_DIV cycles.
REQ-029 SCAN_DIV=1: index advances every cycle.

Reset
REQ-030 rst_n=0 immediately forces: prescaler 0, index 0, shadow 0, pending 0, pending-valid 0, o_an all 1, o_seg FF, o_frame 0.
REQ-031 Reset mid-frame discards pending data; first digit driven after release is digit 0 with shadow 0.
REQ-032 Deassertion is synchronized by the system; first scan output appears on the first clk edge after release.

Structure
REQ-033 Shared package seg_pkg holds the 16 segment pattern constants, SEG_BLANK (FF) and the segment bit-position constants.
REQ-034 Sub-module seg_hex_dec: combinational nibble + dp -> active-low 8-bit pattern, instantiated once on the selected digit.
REQ-035 Index width is clog2(NUM_DIGITS), minimum 1; prescaler width is clog2(SCAN_DIV), minimum 1.

Verification
REQ-036 NUM_DIGITS=4, SCAN_DIV=3, load 0x12AF, all en -> o_an cycles E,D,B,7 every 3 cycles with o_seg ~8E,~EE,~DA,~60 (i.e. 71,11,25,9F).
REQ-037 Load 0x0000 then 0x00A5 mid-frame -> old value held until o_frame pulse, then digit0 = 49, digit1 = 11 (B6, EE inverted).
REQ-038 i_lzs=1, value 0x0070, i_dp=4'b0100 -> digit3 o_seg FF, digit2 o_seg FE (dp only), digit1 1F, digit0 03.
REQ-039 i_en=4'b1011 -> during digit 2 slot o_an=F and o_seg=FF; other digits normal.
REQ-040 i_load on the frame-boundary cycle -> new value visible in frame starting at that boundary; rst_n pulled low mid-frame -> o_an F, o_seg FF same cycle, restart at digit 0 showing 03.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner.
// Segment byte layout (active-high form): bit7..bit1 = a..g, bit0 = dp.
// The display pins are active-low, so these patterns are inverted at the decoder.
package seg_pkg;

    localparam int SEG_DP_BIT = 0;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_A_BIT  = 7;

    // Active-low "everything off" value for o_seg.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-high glyphs for hex digits 0..F, dp bit clear.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   nibble : hex digit to display
//   dp     : 1 = light the decimal point
//   seg    : active-low segment pattern (bit7..bit1 = a..g, bit0 = dp)
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] pat;

    always_comb begin
        pat             = SEG_HEX[nibble];
        pat[SEG_DP_BIT] = pat[SEG_DP_BIT] | dp;
        seg             = ~pat;
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment display scanner.
// Each digit is driven for SCAN_DIV clocks; digit index runs 0..NUM_DIGITS-1.
// New display data is staged in a pending register and only becomes visible
// at a frame boundary, so a frame never shows a mix of old and new digits.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_value    : 4 bits per digit, digit 0 in the low nibble
//   i_dp       : decimal-point request per digit
//   i_en       : live per-digit enable (0 = digit dark, anode off)
//   i_lzs      : live leading-zero suppression enable
//   i_load     : one-cycle strobe capturing i_value / i_dp
//   o_an       : registered active-low one-cold digit select
//   o_seg      : registered active-low segments (a..g, dp)
//   o_frame    : one-cycle pulse after each frame boundary
module seg_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_en,
    input  logic                    i_lzs,
    input  logic                    i_load,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [7:0]              o_seg,
    output logic                    o_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]        pre;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;

    logic                    tc;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_sup;
    logic [NUM_DIGITS-1:0]   sel_an;
    logic [7:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [7:0]              seg_nxt;

    assign tc       = (pre == PRE_LAST);
    assign boundary = tc && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre     <= '0;
            idx     <= '0;
            o_frame <= 1'b0;
        end else begin
            o_frame <= boundary;
            if (tc) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // A load landing on the boundary edge bypasses pending and goes straight
    // to the shadow; any older pending data is superseded and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_valid   <= 1'b0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (i_load) begin
                shadow_value <= i_value;
                shadow_dp    <= i_dp;
            end else if (pend_valid) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
            end
        end else if (i_load) begin
            pend_value <= i_value;
            pend_dp    <= i_dp;
            pend_valid <= 1'b1;
        end
    end

    // Suppression walks down from the most significant digit while the
    // nibbles stay zero; digit 0 is never part of the run.
    always_comb begin
        zero_run  = i_lzs;
        lead_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (shadow_value[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_sup = 1'b0;
        sel_an  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shadow_value[4*k +: 4];
                cur_dp    = shadow_dp[k];
                cur_en    = i_en[k];
                cur_sup   = lead_zero[k];
                sel_an[k] = 1'b0;
            end
        end
    end

    seg_hex_dec u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        if (cur_en) begin
            an_nxt  = sel_an;
            seg_nxt = dec_seg;
            if (cur_sup) begin
                seg_nxt[SEG_A_BIT:SEG_G_BIT] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_an  <= '1;
            o_seg <= SEG_BLANK;
        end else begin
            o_an  <= an_nxt;
            o_seg <= seg_nxt;
        end
    end

endmodule
